// File: rtl/gcd_requester.sv
// Initiator front end for the subtractive GCD engine: resolves zero operands locally,
// otherwise issues the pair to the engine, waits with a timeout and returns the result.
module gcd_requester #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_gcd,
  output logic             eng_abort,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_gcd,
  output logic             resp_err,
  output logic [31:0]      resp_cycles,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      wait_cnt;
  logic             timeout_hit;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;
  logic [31:0]      cyc_q, cyc_d;

  // cnt_q holds completed WAIT cycles, so the current WAIT cycle number is cnt_q+1
  assign wait_cnt    = cnt_q + 32'd1;
  assign timeout_hit = (wait_cnt == TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    gcd_d      = gcd_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    req_ready  = 1'b0;
    eng_start  = 1'b0;
    eng_abort  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          // the subtractive engine never converges on a zero operand
          if (req_a == '0 || req_b == '0) begin
            gcd_d   = req_a | req_b;
            err_d   = 1'b0;
            cyc_d   = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = wait_cnt;
        if (eng_done) begin
          gcd_d   = eng_gcd;
          err_d   = 1'b0;
          cyc_d   = wait_cnt;
          state_d = RESP;
        end else if (timeout_hit) begin
          // abort is gated by eng_done so a last-cycle completion is never aborted
          gcd_d     = '0;
          err_d     = 1'b1;
          cyc_d     = TMO;
          eng_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign eng_a       = a_q;
  assign eng_b       = b_q;
  assign resp_gcd    = gcd_q;
  assign resp_err    = err_q;
  assign resp_cycles = cyc_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed plus random bench for gcd_requester with a behavioural engine model
// and a transaction-level reference for result, error and timing.
module tb_gcd_requester;
  localparam int W   = 32;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         eng_start;
  logic [W-1:0] eng_a, eng_b;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_gcd = '0;
  logic         eng_abort;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_gcd;
  logic         resp_err;
  logic [31:0]  resp_cycles;
  logic         busy;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_gcd(eng_gcd), .eng_abort(eng_abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_gcd(resp_gcd), .resp_err(resp_err), .resp_cycles(resp_cycles),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int eng_delay = 0;   // WAIT cycle in which the engine raises done; 0 = never
  int wcnt = 0;
  bit run = 1'b0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: counts WAIT cycles after the start pulse and answers in cycle eng_delay
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || resp_valid) begin
      run = 1'b0;
      eng_done = 1'b0;
    end else if (eng_start) begin
      run = 1'b1;
      wcnt = 0;
      eng_done = 1'b0;
    end else if (run) begin
      wcnt++;
      eng_done = (eng_delay != 0 && wcnt == eng_delay);
    end else begin
      eng_done = 1'b0;
    end
    eng_gcd = eng_done ? ref_gcd(eng_a, eng_b) : 32'hdead_beef;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and follow it until resp_valid; called at a negedge.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                        input string tag);
    logic [W-1:0] exp_gcd;
    logic         exp_err;
    int exp_cyc, exp_resp_at, exp_start_at, exp_abort_at;
    int cyc, n_start, n_abort, start_at, abort_at, hold_bad;
    bit bypass;
    bypass = (a == 0 || b == 0);
    if (bypass) begin
      exp_gcd = a | b; exp_err = 1'b0; exp_cyc = 0;
      exp_resp_at = 1; exp_start_at = -1; exp_abort_at = -1;
    end else if (delay != 0 && delay <= TMO) begin
      exp_gcd = ref_gcd(a, b); exp_err = 1'b0; exp_cyc = delay;
      exp_resp_at = 2 + delay; exp_start_at = 1; exp_abort_at = -1;
    end else begin
      exp_gcd = '0; exp_err = 1'b1; exp_cyc = TMO;
      exp_resp_at = 2 + TMO; exp_start_at = 1; exp_abort_at = 1 + TMO;
    end
    eng_delay = delay;
    chk({tag, "/req_ready"}, req_ready, 1);
    req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; n_start = 0; n_abort = 0; start_at = -1; abort_at = -1; hold_bad = 0;
    while (!resp_valid && cyc < TMO + 8) begin
      if (eng_start) begin n_start++; start_at = cyc; end
      if (eng_abort) begin n_abort++; abort_at = cyc; end
      if (eng_a !== a || eng_b !== b) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/resp_valid"}, resp_valid, 1);
    chk({tag, "/resp_at"}, cyc, exp_resp_at);
    chk({tag, "/n_start"}, n_start, bypass ? 0 : 1);
    chk({tag, "/start_at"}, start_at, exp_start_at);
    chk({tag, "/n_abort"}, n_abort, (exp_abort_at < 0) ? 0 : 1);
    chk({tag, "/abort_at"}, abort_at, exp_abort_at);
    if (!bypass) chk({tag, "/eng_ab_hold"}, hold_bad, 0);
    chk({tag, "/resp_gcd"}, resp_gcd, exp_gcd);
    chk({tag, "/resp_err"}, resp_err, exp_err);
    chk({tag, "/resp_cycles"}, resp_cycles, exp_cyc);
    chk({tag, "/busy_ready"}, {busy, req_ready}, 2'b10);
  endtask

  // Stall the response for hold cycles, then complete the handshake.
  task automatic finish_resp(input int hold, input string tag);
    logic [W-1:0] g0;
    logic         e0;
    logic [31:0]  c0;
    g0 = resp_gcd; e0 = resp_err; c0 = resp_cycles;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "/hold_valid_ready"}, {resp_valid, req_ready}, 2'b10);
      chk({tag, "/hold_gcd"}, resp_gcd, g0);
      chk({tag, "/hold_err_cyc"}, {resp_err, resp_cycles}, {e0, c0});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "/after_hs"}, {resp_valid, req_ready, busy}, 3'b010);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/ctl"}, {req_ready, eng_start, eng_abort, resp_valid, resp_err, busy}, 6'b100000);
    chk({tag, "/eng_ab"}, {eng_a, eng_b}, 64'd0);
    chk({tag, "/resp_gcd"}, resp_gcd, 0);
    chk({tag, "/resp_cycles"}, resp_cycles, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_release");

    do_req(12, 18, 10, "basic");
    finish_resp(0, "basic");

    do_req(0, 7, 4, "bypass07");
    finish_resp(0, "bypass07");
    do_req(0, 0, 4, "bypass00");
    finish_resp(0, "bypass00");

    do_req(40, 24, 0, "timeout");
    finish_resp(1, "timeout");

    do_req(35, 21, TMO, "done_at_limit");
    finish_resp(0, "done_at_limit");

    // back-pressure with a further request already waiting
    do_req(12, 18, 3, "bp");
    req_a = 0; req_b = 5; req_valid = 1'b1;
    finish_resp(5, "bp");
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next/resp_valid", resp_valid, 1);
    chk("bp_next/resp_gcd", resp_gcd, 5);
    chk("bp_next/resp_cycles", resp_cycles, 0);
    finish_resp(0, "bp_next");

    // reset dropped in WAIT cycle 4
    eng_delay = 0;
    req_a = 20; req_b = 8; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(9, 6, 5, "post_rst");
    finish_resp(0, "post_rst");

    for (int i = 0; i < 25; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 300));
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 300));
      do_req(ra, rb, int'($urandom_range(0, 20)), $sformatf("rand%0d", i));
      finish_resp(int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
